seg7_scan_driver: RTL and testbench

//  Parametrised multiplexed seven-segment scanner for the board display path.

---
 rtl/seg7_scan_driver_if.sv | 30 +++
 rtl/seg7_scan_driver.sv | 168 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - load-side bus of the seven-segment scanner
// Purpose: groups the value/dp load handshake, blanking control and frame status.
// Signals:
//   value      4*NDIG  hex word, nibble i -> digit i
//   dp         NDIG    decimal-point request per digit
//   load       1       1-cycle capture strobe
//   lz_blank   1       leading-zero blanking enable (live)
//   pending    1       shadow holds an uncommitted value
//   frame_tick 1       1-cycle pulse after every frame boundary
// Modports: master drives value/dp/load/lz_blank, slave (the scanner) drives status.
interface seg7_scan_driver_if #(
    parameter int NDIG = 8
);
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   dp;
    logic              load;
    logic              lz_blank;
    logic              pending;
    logic              frame_tick;

    modport master (
        output value, dp, load, lz_blank,
        input  pending, frame_tick
    );

    modport slave (
        input  value, dp, load, lz_blank,
        output pending, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed NDIG-digit seven-segment scanner
// Purpose: scans NDIG digits, one slot of SCAN_DIV cycles each, with a DEAD-cycle
// blank at the start of each slot, leading-zero blanking, per-digit decimal points
// and a shadow register so a new value only commits at the frame boundary.
// Ports:
//   clk     system clock
//   rst     synchronous active-low reset
//   bus     load-side interface (slave modport)
//   dig_en  one-hot digit enable, active high
//   seg     segments {g,f,e,d,c,b,a}, active high
//   seg_dp  decimal-point segment, active high
module seg7_scan_driver #(
    parameter int NDIG     = 8,
    parameter int SCAN_DIV = 100000,
    parameter int DEAD     = 16
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus,
    output logic [NDIG-1:0]     dig_en,
    output logic [6:0]          seg,
    output logic                seg_dp
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NDIG);

    logic [CW-1:0]     div_cnt_q, div_cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] active_q, active_d;
    logic [NDIG-1:0]   active_dp_q, active_dp_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic [NDIG-1:0]   shadow_dp_q, shadow_dp_d;
    logic              pending_q, pending_d;
    logic              frame_tick_q, frame_tick_d;
    logic [NDIG-1:0]   dig_en_q, dig_en_d;
    logic [6:0]        seg_q, seg_d;
    logic              seg_dp_q, seg_dp_d;

    logic              slot_end;
    logic              boundary;
    logic              in_dead;
    logic              blank;
    logic [NDIG-1:0]   upper_zero;
    logic [3:0]        cur_nib;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign slot_end = (div_cnt_q == CW'(SCAN_DIV - 1));
    assign boundary = slot_end && (idx_q == IW'(NDIG - 1));

    // With DEAD=0 there is no blank window; kept out of the compare so the
    // comparison is never against an always-false constant.
    generate
        if (DEAD == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = ({{(32-CW){1'b0}}, div_cnt_q} < 32'(DEAD));
        end
    endgenerate

    // upper_zero[i]: every active nibble from NDIG-1 down to i is zero.
    always_comb begin
        upper_zero = '0;
        upper_zero[NDIG-1] = (active_q[4*(NDIG-1) +: 4] == 4'h0);
        for (int i = NDIG - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (active_q[4*i +: 4] == 4'h0);
        end
    end

    assign cur_nib = active_q[{idx_q, 2'b00} +: 4];
    assign blank   = bus.lz_blank && (idx_q != '0) && upper_zero[idx_q];

    always_comb begin
        div_cnt_d    = slot_end ? '0 : div_cnt_q + 1'b1;
        idx_d        = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end

        active_d     = active_q;
        active_dp_d  = active_dp_q;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        if (boundary) begin
            // A load landing on the boundary bypasses the shadow entirely.
            if (bus.load) begin
                active_d    = bus.value;
                active_dp_d = bus.dp;
            end else if (pending_q) begin
                active_d    = shadow_q;
                active_dp_d = shadow_dp_q;
            end
            pending_d = 1'b0;
        end else if (bus.load) begin
            shadow_d    = bus.value;
            shadow_dp_d = bus.dp;
            pending_d   = 1'b1;
        end

        frame_tick_d = boundary;

        if (in_dead) begin
            dig_en_d = '0;
            seg_d    = '0;
            seg_dp_d = 1'b0;
        end else begin
            dig_en_d = {{(NDIG-1){1'b0}}, 1'b1} << idx_q;
            seg_d    = blank ? 7'h00 : decode(cur_nib);
            seg_dp_d = active_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            dig_en_q     <= '0;
            seg_q        <= '0;
            seg_dp_q     <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            active_dp_q  <= active_dp_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            dig_en_q     <= dig_en_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.frame_tick = frame_tick_q;
    assign dig_en         = dig_en_q;
    assign seg            = seg_q;
    assign seg_dp         = seg_dp_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;
    localparam int N  = 4;
    localparam int SD = 4;
    localparam int DA = 1;
    localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        lz;
    logic [3:0]  dig_a, dig_b;
    logic [6:0]  seg_a, seg_b;
    logic        sdp_a, sdp_b;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NDIG(N)) ifa ();
    seg7_scan_driver_if #(.NDIG(N)) ifb ();

    assign ifa.value = value;
    assign ifa.dp = dp;
    assign ifa.load = load;
    assign ifa.lz_blank = lz;
    assign ifb.value = value;
    assign ifb.dp = dp;
    assign ifb.load = load;
    assign ifb.lz_blank = lz;

    seg7_scan_driver #(.NDIG(N), .SCAN_DIV(SD), .DEAD(DA)) u_a (
        .clk(clk), .rst(rst), .bus(ifa), .dig_en(dig_a), .seg(seg_a), .seg_dp(sdp_a));
    seg7_scan_driver #(.NDIG(N), .SCAN_DIV(SD), .DEAD(0)) u_b (
        .clk(clk), .rst(rst), .bus(ifb), .dig_en(dig_b), .seg(seg_b), .seg_dp(sdp_b));

    int checks = 0;
    int errors = 0;

    // Reference model: position in the scan derived purely from cycles since reset.
    int          t;
    logic [15:0] m_act, m_shd;
    logic [3:0]  m_act_dp, m_shd_dp;
    bit          m_pend;
    logic [3:0]  e_dig_a, e_dig_b;
    logic [6:0]  e_seg_a, e_seg_b;
    logic        e_sdp_a, e_sdp_b, e_pend, e_ft;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, t, got, exp);
        end
    endtask

    task automatic tick();
        int slot, ph;
        bit b, blank;
        logic [6:0] s;
        if (!rst) begin
            t = 0; m_act = 0; m_shd = 0; m_act_dp = 0; m_shd_dp = 0; m_pend = 0;
            e_dig_a = 0; e_seg_a = 0; e_sdp_a = 0;
            e_dig_b = 0; e_seg_b = 0; e_sdp_b = 0;
            e_pend = 0; e_ft = 0;
        end else begin
            slot  = (t / SD) % N;
            ph    = t % SD;
            b     = ((t % (N * SD)) == N * SD - 1);
            blank = lz && (slot > 0) && ((m_act >> (4 * slot)) == 16'h0);
            s     = blank ? 7'h00 : DEC[m_act[4*slot +: 4]];
            e_dig_b = 4'(1 << slot);
            e_seg_b = s;
            e_sdp_b = m_act_dp[slot];
            if (ph < DA) begin
                e_dig_a = 0; e_seg_a = 0; e_sdp_a = 0;
            end else begin
                e_dig_a = e_dig_b; e_seg_a = e_seg_b; e_sdp_a = e_sdp_b;
            end
            e_ft = b;
            if (b) begin
                if (load) begin
                    m_act = value; m_act_dp = dp;
                end else if (m_pend) begin
                    m_act = m_shd; m_act_dp = m_shd_dp;
                end
                m_pend = 0;
            end else if (load) begin
                m_shd = value; m_shd_dp = dp; m_pend = 1;
            end
            e_pend = m_pend;
            t++;
        end
        @(posedge clk);
        #1;
        chk("m_dig_a", 32'(dig_a), 32'(e_dig_a));
        chk("m_seg_a", 32'(seg_a), 32'(e_seg_a));
        chk("m_sdp_a", 32'(sdp_a), 32'(e_sdp_a));
        chk("m_pend_a", 32'(ifa.pending), 32'(e_pend));
        chk("m_ft_a", 32'(ifa.frame_tick), 32'(e_ft));
        chk("m_dig_b", 32'(dig_b), 32'(e_dig_b));
        chk("m_seg_b", 32'(seg_b), 32'(e_seg_b));
        chk("m_sdp_b", 32'(sdp_b), 32'(e_sdp_b));
        chk("m_pend_b", 32'(ifb.pending), 32'(e_pend));
        chk("m_ft_b", 32'(ifb.frame_tick), 32'(e_ft));
        if (rst && t >= 2) chk("dead0_nonzero", 32'(dig_b != 0), 32'd1);
    endtask

    // Idle until the outputs of cycle k (since reset release) are visible.
    task automatic run_through(input int k);
        load = 0;
        while (t <= k) tick();
    endtask

    typedef struct {
        bit          rst;
        bit          load;
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  dig;
        logic [6:0]  seg;
        bit          sdp;
        bit          pend;
        bit          ft;
    } vec_t;

    vec_t vt[10];
    logic [6:0] exp_commit [4] = '{7'h71, 7'h4F, 7'h77, 7'h06};

    initial begin
        rst = 0; load = 0; value = 0; dp = 0; lz = 0; t = 0;

        vt[0] = '{0, 0, 16'h0000, 4'h0, 4'h0, 7'h00, 0, 0, 0};
        vt[1] = '{0, 0, 16'h0000, 4'h0, 4'h0, 7'h00, 0, 0, 0};
        vt[2] = '{0, 0, 16'h0000, 4'h0, 4'h0, 7'h00, 0, 0, 0};
        vt[3] = '{1, 0, 16'h0000, 4'h0, 4'h0, 7'h00, 0, 0, 0};
        vt[4] = '{1, 0, 16'h0000, 4'h0, 4'h1, 7'h3F, 0, 0, 0};
        vt[5] = '{1, 0, 16'h0000, 4'h0, 4'h1, 7'h3F, 0, 0, 0};
        vt[6] = '{1, 0, 16'h0000, 4'h0, 4'h1, 7'h3F, 0, 0, 0};
        vt[7] = '{1, 0, 16'h0000, 4'h0, 4'h0, 7'h00, 0, 0, 0};
        vt[8] = '{1, 1, 16'h1A3F, 4'h4, 4'h2, 7'h3F, 0, 1, 0};
        vt[9] = '{1, 0, 16'h0000, 4'h0, 4'h2, 7'h3F, 0, 1, 0};

        // Reset, first slots, and the load at frame cycle 5
        for (int i = 0; i < 10; i++) begin
            rst = vt[i].rst; load = vt[i].load; value = vt[i].value; dp = vt[i].dp;
            tick();
            chk("tbl_dig", 32'(dig_a), 32'(vt[i].dig));
            chk("tbl_seg", 32'(seg_a), 32'(vt[i].seg));
            chk("tbl_sdp", 32'(sdp_a), 32'(vt[i].sdp));
            chk("tbl_pend", 32'(ifa.pending), 32'(vt[i].pend));
            chk("tbl_ft", 32'(ifa.frame_tick), 32'(vt[i].ft));
        end

        // Commit at B (cycle 15), shown through the next frame
        run_through(14);
        chk("commit_pend_before_b", 32'(ifa.pending), 32'd1);
        run_through(15);
        chk("commit_ft", 32'(ifa.frame_tick), 32'd1);
        chk("commit_pend_after_b", 32'(ifa.pending), 32'd0);
        for (int s = 0; s < 4; s++) begin
            run_through(16 + 4 * s);
            chk("dead_dig", 32'(dig_a), 32'd0);
            chk("dead_seg", 32'(seg_a), 32'd0);
            if (s == 0) chk("commit_ft_once", 32'(ifa.frame_tick), 32'd0);
            run_through(17 + 4 * s);
            chk("commit_dig", 32'(dig_a), 32'(1 << s));
            chk("commit_seg", 32'(seg_a), 32'(exp_commit[s]));
            chk("commit_sdp", 32'(sdp_a), 32'(s == 2));
        end

        // Overwrite before B, then a load coinciding with B
        run_through(32);
        load = 1; value = 16'h1111; dp = 0; tick();
        run_through(39);
        load = 1; value = 16'h2222; tick();
        run_through(47);
        for (int s = 0; s < 4; s++) begin
            run_through(49 + 4 * s);
            chk("overwrite_seg", 32'(seg_a), 32'h5B);
        end
        run_through(62);
        load = 1; value = 16'h3333; tick();
        chk("coincide_pend", 32'(ifa.pending), 32'd0);
        chk("coincide_ft", 32'(ifa.frame_tick), 32'd1);
        run_through(65);
        chk("coincide_seg", 32'(seg_a), 32'h4F);
        chk("coincide_pend2", 32'(ifa.pending), 32'd0);

        // Leading-zero blanking
        run_through(70);
        lz = 1; load = 1; value = 16'h0050; dp = 4'b1000; tick();
        run_through(79);
        run_through(81); chk("lz_d0_dig", 32'(dig_a), 32'h1); chk("lz_d0_seg", 32'(seg_a), 32'h3F);
        run_through(85); chk("lz_d1_dig", 32'(dig_a), 32'h2); chk("lz_d1_seg", 32'(seg_a), 32'h6D);
        run_through(89); chk("lz_d2_dig", 32'(dig_a), 32'h4); chk("lz_d2_seg", 32'(seg_a), 32'h00);
        run_through(93); chk("lz_d3_dig", 32'(dig_a), 32'h8); chk("lz_d3_seg", 32'(seg_a), 32'h00);
        chk("lz_d3_sdp", 32'(sdp_a), 32'd1);
        run_through(95);
        load = 1; value = 16'h0000; dp = 0; tick();
        run_through(111);
        for (int s = 0; s < 4; s++) begin
            run_through(113 + 4 * s);
            chk("lz0_dig", 32'(dig_a), 32'(1 << s));
            chk("lz0_seg", 32'(seg_a), (s == 0) ? 32'h3F : 32'h00);
        end

        // Reset mid-frame with a pending value
        run_through(130);
        lz = 0; load = 1; value = 16'h9999; dp = 4'hF; tick();
        chk("rst_pend_set", 32'(ifa.pending), 32'd1);
        load = 0; rst = 0; tick(); tick();
        chk("rst_pend_clr", 32'(ifa.pending), 32'd0);
        chk("rst_dig_clr", 32'(dig_a), 32'd0);
        rst = 1;
        run_through(1);
        chk("rst_idx0", 32'(dig_a), 32'h1);
        for (int k = 2; k < 40; k++) begin
            run_through(k);
            if (dig_a != 0) chk("rst_no_old", 32'(seg_a), 32'h3F);
        end
        chk("rst_pend_stay", 32'(ifa.pending), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(0, 299) != 0);
            load  = ($urandom_range(0, 6) == 0);
            value = 16'($urandom >> $urandom_range(16, 31));
            dp    = 4'($urandom);
            if ($urandom_range(0, 19) == 0) lz = ~lz;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
